// File: rtl/cussen_seq.sv
// cussen_seq: time-shares one 9-input sort engine across a serial sample stream.
//
// Frame flow: FILL gathers N samples into the sorter input slots, WAIT holds them
// stable for SORT_LAT cycles, and the sorted vector and unique count are then
// captured and streamed out in DRAIN. Frames never overlap.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             synchronous abort of the current frame
//   s_valid/s_ready   input sample handshake, s_data = sample
//   srt_in            packed sorter inputs (slot 0 in the low W bits)
//   srt_out, srt_uniq sorter results (slot 0 = smallest) and unique count
//   m_valid/m_ready   output sample handshake, m_data = sorted sample
//   m_last            marks the final sample of a frame
//   m_uniq            unique count of the frame being drained (held until next capture)
//   sort_err          sticky: a captured vector was not nondecreasing
//   frames_done       completed-frame counter (wraps)
module cussen_seq #(
  parameter int unsigned N        = 9,
  parameter int unsigned W        = 8,
  parameter int unsigned SORT_LAT = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [W-1:0]   s_data,
  output logic [N*W-1:0] srt_in,
  input  logic [N*W-1:0] srt_out,
  input  logic [3:0]     srt_uniq,
  output logic           m_valid,
  input  logic           m_ready,
  output logic [W-1:0]   m_data,
  output logic           m_last,
  output logic [3:0]     m_uniq,
  output logic           sort_err,
  output logic [15:0]    frames_done
);

  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);
  localparam logic [7:0]      LatLast = 8'(SORT_LAT - 1);

  typedef enum logic [1:0] {StFill, StWait, StDrain} state_e;

  state_e          r_state;
  logic [IdxW-1:0] r_fill_idx;
  logic [IdxW-1:0] r_drain_idx;
  logic [7:0]      r_wait_cnt;
  logic [W-1:0]    r_slot [N];
  logic [W-1:0]    r_res  [N];
  logic [3:0]      r_uniq;
  logic            r_sort_err;
  logic [15:0]     r_frames;
  logic            w_unsorted;

  // Any descending adjacent pair in the raw sorter output flags a bad sort.
  always_comb begin
    w_unsorted = 1'b0;
    for (int k = 0; k < int'(N) - 1; k++) begin
      if (srt_out[k*W +: W] > srt_out[(k+1)*W +: W]) w_unsorted = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StFill;
      r_fill_idx  <= '0;
      r_drain_idx <= '0;
      r_wait_cnt  <= '0;
      r_uniq      <= '0;
      r_sort_err  <= 1'b0;
      r_frames    <= '0;
      for (int k = 0; k < int'(N); k++) begin
        r_slot[k] <= '0;
        r_res[k]  <= '0;
      end
    end else if (flush) begin
      // Abort wins over any handshake or capture this cycle.
      r_state     <= StFill;
      r_fill_idx  <= '0;
      r_drain_idx <= '0;
      r_wait_cnt  <= '0;
    end else begin
      unique case (r_state)
        StFill: begin
          if (s_valid) begin
            r_slot[r_fill_idx] <= s_data;
            if (r_fill_idx == LastIdx) begin
              r_state    <= StWait;
              r_fill_idx <= '0;
              r_wait_cnt <= '0;
            end else begin
              r_fill_idx <= r_fill_idx + 1'b1;
            end
          end
        end
        StWait: begin
          if (r_wait_cnt == LatLast) begin
            for (int k = 0; k < int'(N); k++) begin
              r_res[k] <= srt_out[k*W +: W];
            end
            r_uniq      <= srt_uniq;
            r_state     <= StDrain;
            r_drain_idx <= '0;
            if (w_unsorted) r_sort_err <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        StDrain: begin
          if (m_ready) begin
            if (r_drain_idx == LastIdx) begin
              r_state     <= StFill;
              r_fill_idx  <= '0;
              r_drain_idx <= '0;
              r_frames    <= r_frames + 16'd1;
            end else begin
              r_drain_idx <= r_drain_idx + 1'b1;
            end
          end
        end
        default: r_state <= StFill;
      endcase
    end
  end

  always_comb begin
    srt_in = '0;
    for (int k = 0; k < int'(N); k++) begin
      srt_in[k*W +: W] = r_slot[k];
    end
  end

  assign s_ready     = (r_state == StFill);
  assign m_valid     = (r_state == StDrain);
  assign m_data      = r_res[r_drain_idx];
  assign m_last      = (r_state == StDrain) && (r_drain_idx == LastIdx);
  assign m_uniq      = r_uniq;
  assign sort_err    = r_sort_err;
  assign frames_done = r_frames;

endmodule
